// File: rtl/serout_pkg.sv
// Shared definitions for the POKEY serial output path: state encoding,
// SEROUT register address and frame-length derivation.
package serout_pkg;

    typedef enum logic {
        SDO_IDLE  = 1'b0,
        SDO_SHIFT = 1'b1
    } sdoState_t;

    localparam logic [15:0] SEROUT_ADDR = 16'hD20D;

    // Start bit + data bits + stop bits.
    function automatic int unsigned frameLen(input int unsigned dataBits,
                                             input int unsigned stopBits);
        return 1 + dataBits + stopBits;
    endfunction

endpackage

// File: rtl/serout_shifter.sv
// Frame shift register and bit-index counter for the serial output line.
// shReg[0] is the bit currently on the line; vacated positions fill with 1.
module serout_shifter
    import serout_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 load,
    input  logic                 advance,
    input  logic                 forceLow,
    input  logic [DATA_BITS-1:0] loadData,
    output logic                 sod,
    output logic                 lastBit
);

    localparam int unsigned FRAME_LEN = frameLen(DATA_BITS, STOP_BITS);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);

    logic [FRAME_LEN-1:0] shReg;
    logic [FRAME_LEN-1:0] shNext;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idxNext;

    // Load takes priority so a back-to-back frame replaces the finishing one.
    always_comb begin
        shNext  = shReg;
        idxNext = idx;
        if (load) begin
            shNext  = {{STOP_BITS{1'b1}}, loadData, 1'b0};
            idxNext = '0;
        end else if (advance) begin
            shNext  = {1'b1, shReg[FRAME_LEN-1:1]};
            idxNext = lastBit ? '0 : idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            shReg   <= '1;
            idx     <= '0;
            sod     <= 1'b1;
            lastBit <= 1'b0;
        end else begin
            shReg   <= shNext;
            idx     <= idxNext;
            sod     <= shNext[0] & ~forceLow;
            lastBit <= (idxNext == IDX_W'(FRAME_LEN - 1));
        end
    end

endmodule

// File: rtl/serout_ctrl.sv
// SEROUT sequencer: holding register, frame FSM and serial IRQ/overrun flags.
// Optional SEROUT_BREAK_EN adds forceBreak, which holds sod low without
// disturbing framing.
module serout_ctrl
    import serout_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 serOutWr,
    input  logic [DATA_BITS-1:0] serOutData,
    input  logic                 bitTick,
    input  logic                 overrunClr,
`ifdef SEROUT_BREAK_EN
    input  logic                 forceBreak,
`endif
    output logic                 sod,
    output logic                 needIrq,
    output logic                 doneIrq,
    output logic                 busy,
    output logic                 overrun
);

    sdoState_t            state;
    sdoState_t            stateNext;
    logic                 holdFull;
    logic                 holdFullNext;
    logic [DATA_BITS-1:0] holdData;
    logic                 doneIrqNext;
    logic                 overrunNext;
    logic                 transfer;
    logic                 advance;
    logic                 frameEnd;
    logic                 lastBit;
    logic                 breakLow;

`ifdef SEROUT_BREAK_EN
    assign breakLow = forceBreak;
`else
    assign breakLow = 1'b0;
`endif

    // Next-state and flag logic; a write always wins over transfer/clear.
    always_comb begin
        stateNext    = state;
        holdFullNext = holdFull;
        doneIrqNext  = doneIrq;
        overrunNext  = overrun;
        advance      = bitTick && (state == SDO_SHIFT);
        frameEnd     = advance && lastBit;
        transfer     = holdFull && ((bitTick && (state == SDO_IDLE)) || frameEnd);

        case (state)
            SDO_IDLE:  if (transfer) stateNext = SDO_SHIFT;
            SDO_SHIFT: if (frameEnd && !holdFull) stateNext = SDO_IDLE;
            default:   stateNext = SDO_IDLE;
        endcase

        if (transfer)
            holdFullNext = 1'b0;
        if (serOutWr)
            holdFullNext = 1'b1;

        if (frameEnd && !holdFull)
            doneIrqNext = 1'b1;
        if (serOutWr)
            doneIrqNext = 1'b0;

        if (overrunClr)
            overrunNext = 1'b0;
        if (serOutWr && holdFull && !transfer)
            overrunNext = 1'b1;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state    <= SDO_IDLE;
            holdFull <= 1'b0;
            holdData <= '0;
            needIrq  <= 1'b0;
            doneIrq  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= stateNext;
            holdFull <= holdFullNext;
            if (serOutWr)
                holdData <= serOutData;
            needIrq  <= transfer;
            doneIrq  <= doneIrqNext;
            busy     <= (stateNext == SDO_SHIFT);
            overrun  <= overrunNext;
        end
    end

    serout_shifter #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) uShifter (
        .clk      (clk),
        .nReset   (nReset),
        .load     (transfer),
        .advance  (advance),
        .forceLow (breakLow),
        .loadData (holdData),
        .sod      (sod),
        .lastBit  (lastBit)
    );

endmodule

// File: doc/serout_ctrl.md
Name: serout_ctrl

Overview:
- Sequencer for the POKEY serial output path. Buffers CPU writes to SEROUT (D20D) in a holding register and moves them into a frame shift register on serial bit ticks.
- Frames each byte as start / data LSB-first / stop and drives the SOD line.
- Raises the "serial output data needed" and "transmission finished" interrupt requests toward IRQEN/IRQST logic.

Parameters:
- DATA_BITS, 8, data bits per frame.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock.
- nReset  input  1  asynchronous active-low reset.
- serOutWr  input  1  one-cycle CPU write strobe to SEROUT.
- serOutData  input  DATA_BITS  write data.
- bitTick  input  1  one-cycle serial bit-rate enable (channel 4 timer or external clock, selected upstream).
- sod  output  1  serial data out line.
- needIrq  output  1  one-cycle pulse: holding register emptied.
- doneIrq  output  1  level: shifter idle and holding register empty.
- busy  output  1  frame in progress.
- overrun  output  1  sticky: write landed on a full holding register.
- overrunClr  input  1  one-cycle clear for overrun.

Behaviour:
- Reset (async, nReset low) values: sod=1, needIrq=0, doneIrq=0, busy=0, overrun=0, holdFull=0, state=IDLE, bit index=0. Reset mid-frame abandons the frame; the line returns to 1 immediately.
- Frame length F = 1 + DATA_BITS + STOP_BITS ticks. Bit-index width is clog2(F).
- Holding register: serOutWr loads serOutData and sets holdFull=1, doneIrq=0. A write while holdFull=1 overwrites the data and sets overrun=1. overrunClr clears overrun; a simultaneous write-with-overrun wins over the clear.
- State IDLE:
  - sod=1.
  - On a cycle with bitTick=1 and holdFull=1: transfer holding→shifter, holdFull=0, pulse needIrq next cycle, go to SHIFT with index=0, sod=0 (start bit) from the next cycle.
- State SHIFT:
  - Each bitTick increments the index.
  - sod presents: start bit at index 0; data bit k at index 1+k; 1 at indices ≥1+DATA_BITS.
  - busy=1 throughout SHIFT.
  - On the tick ending index F-1, if holdFull=1: transfer back-to-back, index=0, sod=0, needIrq pulse. No idle bit is inserted.
  - On the tick ending index F-1, if holdFull=0: go to IDLE, busy=0, doneIrq=1.
- Simultaneous write and transfer in the same cycle: the shifter takes the old holding content. The new data lands in holding, holdFull=1, needIrq still pulses, no overrun.
- Simultaneous write and frame end with holding empty: the write wins. holdFull=1, doneIrq stays 0, state goes IDLE, and the next bitTick starts the frame.
- bitTick with no pending data in IDLE: no effect.
- serOutWr while doneIrq=1 clears doneIrq in the following cycle.
- All outputs are registered; no combinational path from inputs to sod.

Optional Feature:
- Macro SEROUT_BREAK_EN.
- Defined: adds input forceBreak (SKCTL bit 7). While forceBreak=1, sod=0 regardless of state, and framing/tick counting continue unchanged. sod reverts to framed output in the cycle after forceBreak falls.
- Undefined: the port is absent and sod is purely framed output.

Decomposition:
- Shared include/package holds:
  - state encodings (SDO_IDLE, SDO_SHIFT);
  - SEROUT register address constant;
  - frame-length constant derivation.
- One sub-module, serout_shifter: frame shift register plus bit-index counter, with load/advance inputs and lastBit/sod outputs.
- serout_ctrl owns the holding register, FSM and IRQ/overrun logic.

Test Plan:
- Reset then write 0xA5, bitTick every 4 clocks → sod sequence 0,1,0,1,0,0,1,0,1,1. needIrq pulses once at the first tick. doneIrq rises after the 10th tick; busy is low after it.
- Write 0x3C, then write 0x81 during 0x3C's data bits → two frames back-to-back with no idle bit. needIrq pulses twice. doneIrq stays 0 until the second stop bit ends.
- Two writes before any bitTick → overrun=1, transmitted byte is the second. overrunClr → overrun=0.
- Write coincident with the transfer tick → first byte shifted, second held, holdFull=1, no overrun.
- Assert nReset mid-frame (index 4) → sod=1, busy=0, doneIrq=0 immediately. Next write plus tick starts a clean frame.
- SEROUT_BREAK_EN defined: forceBreak=1 during a frame → sod=0 for its duration. The frame ends on the expected tick count with doneIrq=1.
